// File: rtl/dcache_sram_1rw1r.sv
// ---------------------------------------------------------------------------
// dcache_sram_1rw1r
//
// Single-clock behavioural SRAM model for the data-cache data and tag stores.
// Port 0 reads or writes, with a per-lane write mask. Port 1 only reads.
// Both read ports have one cycle of latency and registered outputs. A
// same-address port-0 write and port-1 read can either forward the newly
// merged word to port 1 or return the old word.
//
// After reset an optional sweep writes zero to every word. While the array
// is in reset or sweeping, `busy` is high and all requests are dropped.
//
// Parameters
//   DATA_WIDTH      bits per word
//   ADDR_WIDTH      address bits, RAM_DEPTH = 1 << ADDR_WIDTH
//   WRITE_SIZE      bits per write-mask lane (DATA_WIDTH must be a multiple)
//   NUM_WMASKS      derived lane count, DATA_WIDTH / WRITE_SIZE
//   BYPASS          1: a colliding port-1 read returns the merged new word
//                   0: it returns the old word
//   CLEAR_ON_RESET  1: zero the whole array after reset; 0: no sweep
//
// Ports
//   clk0            clock; all state changes on its rising edge
//   rst             synchronous active-high reset
//   csb0, web0      port 0 chip select / write enable (both active low)
//   wmask0          port 0 per-lane write enable
//   addr0, din0     port 0 address and write data
//   dout0           port 0 registered read data
//   csb1, addr1     port 1 chip select (active low) and address
//   dout1           port 1 registered read data
//   busy            high while in reset or sweeping; requests are ignored
// ---------------------------------------------------------------------------
module dcache_sram_1rw1r #(
    parameter  int DATA_WIDTH     = 128,
    parameter  int ADDR_WIDTH     = 4,
    parameter  int WRITE_SIZE     = 8,
    parameter  bit BYPASS         = 1'b1,
    parameter  bit CLEAR_ON_RESET = 1'b1,
    localparam int NUM_WMASKS     = DATA_WIDTH / WRITE_SIZE
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  busy
);

    localparam int                    RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [ADDR_WIDTH-1:0]  clr_addr_r;
    logic [ADDR_WIDTH-1:0]  clr_addr_next_s;

    logic [DATA_WIDTH-1:0]  mem_r [RAM_DEPTH];

    logic [DATA_WIDTH-1:0]  dout0_r;
    logic [DATA_WIDTH-1:0]  dout1_r;
    logic                   busy_r;

    logic                   ready_s;
    logic                   p0_wr_s;
    logic                   p0_rd_s;
    logic                   p1_rd_s;
    logic                   collide_s;
    logic [DATA_WIDTH-1:0]  p0_merged_s;
    logic [DATA_WIDTH-1:0]  p1_data_s;

    logic                   mem_we_s;
    logic [ADDR_WIDTH-1:0]  mem_waddr_s;
    logic [DATA_WIDTH-1:0]  mem_wdata_s;

    // Lane-wise merge: take new_word where the mask bit is set, old_word elsewhere.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_WMASKS-1:0] mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (mask[i]) begin
                res[i*WRITE_SIZE +: WRITE_SIZE] = new_word[i*WRITE_SIZE +: WRITE_SIZE];
            end else begin
                res[i*WRITE_SIZE +: WRITE_SIZE] = old_word[i*WRITE_SIZE +: WRITE_SIZE];
            end
        end
        return res;
    endfunction

    // State and sweep-counter registers; reset wins from any state.
    always_ff @(posedge clk0) begin
        if (rst) begin
            state_r    <= ST_RESET;
            clr_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r    <= state_next_s;
            clr_addr_r <= clr_addr_next_s;
        end
    end

    // Next state and sweep-counter advance. The sweep exits on the last
    // address rather than on wrap, so the counter never overflows.
    always_comb begin
        state_next_s    = state_r;
        clr_addr_next_s = clr_addr_r;
        case (state_r)
            ST_RESET: begin
                clr_addr_next_s = {ADDR_WIDTH{1'b0}};
                if (CLEAR_ON_RESET) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_READY;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_r == CLR_LAST) begin
                    state_next_s    = ST_READY;
                    clr_addr_next_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_next_s    = ST_CLEAR;
                    clr_addr_next_s = clr_addr_r + ADDR_WIDTH'(1'b1);
                end
            end
            ST_READY: begin
                state_next_s    = ST_READY;
                clr_addr_next_s = {ADDR_WIDTH{1'b0}};
            end
            default: begin
                state_next_s    = ST_RESET;
                clr_addr_next_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // Request qualification and port-1 forwarding selection.
    always_comb begin
        ready_s     = (state_r == ST_READY) && !rst;
        p0_wr_s     = ready_s && !csb0 && !web0;
        p0_rd_s     = ready_s && !csb0 &&  web0;
        p1_rd_s     = ready_s && !csb1;
        p0_merged_s = merge_lanes(mem_r[addr0], din0, wmask0);
        collide_s   = BYPASS && p0_wr_s && p1_rd_s && (addr0 == addr1);
        if (collide_s) begin
            p1_data_s = p0_merged_s;
        end else begin
            p1_data_s = mem_r[addr1];
        end
    end

    // Single array write port, shared by the clear sweep and port-0 writes.
    // The sweep ignores the masks and writes a whole zero word.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {ADDR_WIDTH{1'b0}};
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        if (!rst && (state_r == ST_CLEAR)) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_addr_r;
            mem_wdata_s = {DATA_WIDTH{1'b0}};
        end else if (p0_wr_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = addr0;
            mem_wdata_s = p0_merged_s;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array; deliberately not reset, only the sweep clears it.
    always_ff @(posedge clk0) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Registered read data and busy flag. Read data holds unless a read is accepted.
    always_ff @(posedge clk0) begin
        if (rst) begin
            dout0_r <= {DATA_WIDTH{1'b0}};
            dout1_r <= {DATA_WIDTH{1'b0}};
            busy_r  <= 1'b1;
        end else begin
            busy_r <= (state_next_s != ST_READY);
            if (p0_rd_s) begin
                dout0_r <= mem_r[addr0];
            end
            if (p1_rd_s) begin
                dout1_r <= p1_data_s;
            end
        end
    end

    assign dout0 = dout0_r;
    assign dout1 = dout1_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_dcache_sram_1rw1r.sv
// ---------------------------------------------------------------------------
// tb_dcache_sram_1rw1r
//
// Directed bench for dcache_sram_1rw1r. Three instances share every input:
//   u_dut   default parameters (BYPASS = 1, CLEAR_ON_RESET = 1)
//   u_nobyp BYPASS = 0
//   u_noclr CLEAR_ON_RESET = 0
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at the same point, so everything observed reflects the edge just passed.
// ---------------------------------------------------------------------------
module tb_dcache_sram_1rw1r;

    localparam int DW = 128;
    localparam int AW = 4;
    localparam int NW = 16;

    logic          clk0 = 1'b0;
    logic          rst;
    logic          csb0;
    logic          web0;
    logic [NW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic          csb1;
    logic [AW-1:0] addr1;

    logic [DW-1:0] dout0_a_s, dout1_a_s, dout0_b_s, dout1_b_s, dout0_c_s, dout1_c_s;
    logic          busy_a_s, busy_b_s, busy_c_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk0 = ~clk0;

    dcache_sram_1rw1r u_dut (
        .clk0(clk0), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0_a_s),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_a_s), .busy(busy_a_s)
    );

    dcache_sram_1rw1r #(.BYPASS(1'b0)) u_nobyp (
        .clk0(clk0), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0_b_s),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_b_s), .busy(busy_b_s)
    );

    dcache_sram_1rw1r #(.CLEAR_ON_RESET(1'b0)) u_noclr (
        .clk0(clk0), .rst(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0_c_s),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_c_s), .busy(busy_c_s)
    );

    task automatic tick;
        @(posedge clk0);
        #1;
    endtask

    task automatic go_idle;
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = 16'h0000;
        addr0  = 4'd0;
        din0   = {DW{1'b0}};
        csb1   = 1'b1;
        addr1  = 4'd0;
    endtask

    // Reset values, sweep length, and write gating while busy.
    task automatic test_reset;
        int cnt;
        rst = 1'b1;
        go_idle();
        tick();
        tick();
        n_checks++;
        if (dout0_a_s !== {DW{1'b0}}) begin
            n_fail++; $display("FAIL reset_dout0: got %h expected 0", dout0_a_s);
        end
        n_checks++;
        if (dout1_a_s !== {DW{1'b0}}) begin
            n_fail++; $display("FAIL reset_dout1: got %h expected 0", dout1_a_s);
        end
        n_checks++;
        if (busy_a_s !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 1", busy_a_s);
        end
        n_checks++;
        if (busy_c_s !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy_noclr: got %b expected 1", busy_c_s);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy_c_s !== 1'b0) begin
            n_fail++; $display("FAIL noclr_busy_drop: got %b expected 0", busy_c_s);
        end
        // Attempt a write of 1 to address 0 for the whole sweep.
        csb0   = 1'b0;
        web0   = 1'b0;
        addr0  = 4'd0;
        din0   = 128'd1;
        wmask0 = 16'hFFFF;
        cnt = 0;
        while (busy_a_s === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        go_idle();
        n_checks++;
        if (cnt !== 16) begin
            n_fail++; $display("FAIL sweep_busy_cycles: got %0d expected 16", cnt);
        end
        n_checks++;
        if (dout0_a_s !== {DW{1'b0}}) begin
            n_fail++; $display("FAIL busy_dout0_hold: got %h expected 0", dout0_a_s);
        end
    endtask

    // After the sweep: gated write lost, whole array reads zero on port 1.
    task automatic test_busy_gating;
        csb0  = 1'b0;
        web0  = 1'b1;
        addr0 = 4'd0;
        tick();
        n_checks++;
        if (dout0_a_s !== {DW{1'b0}}) begin
            n_fail++; $display("FAIL gated_write_addr0: got %h expected 0", dout0_a_s);
        end
        n_checks++;
        if (dout0_c_s !== 128'd1) begin
            n_fail++; $display("FAIL noclr_write_addr0: got %h expected 1", dout0_c_s);
        end
        go_idle();
        csb1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr1 = 4'(i);
            tick();
            n_checks++;
            if (dout1_a_s !== {DW{1'b0}} || dout1_b_s !== {DW{1'b0}}) begin
                n_fail++;
                $display("FAIL clear_read_addr%0d: got %h / %h expected 0", i, dout1_a_s, dout1_b_s);
            end
        end
        go_idle();
    endtask

    // Lane masking: only enabled bytes change, zero mask is a no-op.
    task automatic test_masked_write;
        logic [DW-1:0] exp_s;
        csb0   = 1'b0;
        web0   = 1'b0;
        addr0  = 4'd3;
        din0   = 128'h00FF_EEDD_CCBB_AA99_8877_6655_4433_2211;
        wmask0 = 16'h00F0;
        tick();
        n_checks++;
        if (dout0_a_s !== {DW{1'b0}}) begin
            n_fail++; $display("FAIL write_dout0_hold: got %h expected 0", dout0_a_s);
        end
        web0 = 1'b1;
        tick();
        exp_s = 128'h0000_0000_0000_0000_8877_6655_0000_0000;
        n_checks++;
        if (dout0_a_s !== exp_s || dout0_b_s !== exp_s) begin
            n_fail++; $display("FAIL mask_00f0: got %h expected %h", dout0_a_s, exp_s);
        end
        web0   = 1'b0;
        din0   = {DW{1'b1}};
        wmask0 = 16'h8001;
        tick();
        web0   = 1'b0;
        din0   = {DW{1'b1}};
        wmask0 = 16'h0000;
        tick();
        web0 = 1'b1;
        tick();
        exp_s = 128'hFF00_0000_0000_0000_8877_6655_0000_00FF;
        n_checks++;
        if (dout0_a_s !== exp_s) begin
            n_fail++; $display("FAIL mask_8001_then_zero: got %h expected %h", dout0_a_s, exp_s);
        end
        go_idle();
    endtask

    // Same-address write/read collision with and without forwarding.
    task automatic test_collision;
        logic [DW-1:0] old_s;
        logic [DW-1:0] merged_s;
        old_s    = {16{8'hAA}};
        merged_s = {{12{8'hAA}}, {4{8'h55}}};
        csb0   = 1'b0;
        web0   = 1'b0;
        addr0  = 4'd5;
        din0   = old_s;
        wmask0 = 16'hFFFF;
        tick();
        din0   = {16{8'h55}};
        wmask0 = 16'h000F;
        csb1   = 1'b0;
        addr1  = 4'd5;
        tick();
        n_checks++;
        if (dout1_a_s !== merged_s) begin
            n_fail++; $display("FAIL collide_bypass1: got %h expected %h", dout1_a_s, merged_s);
        end
        n_checks++;
        if (dout1_b_s !== old_s) begin
            n_fail++; $display("FAIL collide_bypass0: got %h expected %h", dout1_b_s, old_s);
        end
        // Next cycle: port 0 writes a different address, port 1 rereads 5.
        addr0  = 4'd6;
        din0   = {DW{1'b1}};
        wmask0 = 16'hFFFF;
        tick();
        n_checks++;
        if (dout1_a_s !== merged_s || dout1_b_s !== merged_s) begin
            n_fail++;
            $display("FAIL collide_reread: got %h / %h expected %h", dout1_a_s, dout1_b_s, merged_s);
        end
        go_idle();
    endtask

    // Streaming writes with port 1 trailing one address behind.
    task automatic test_back_to_back;
        logic [DW-1:0] exp_s;
        for (int i = 0; i < 16; i++) begin
            csb0   = 1'b0;
            web0   = 1'b0;
            wmask0 = 16'hFFFF;
            addr0  = 4'(i);
            din0   = 128'(i * 3);
            csb1   = (i == 0) ? 1'b1 : 1'b0;
            addr1  = 4'(i - 1);
            tick();
            if (i > 0) begin
                exp_s = 128'((i - 1) * 3);
                n_checks++;
                if (dout1_a_s !== exp_s || dout1_b_s !== exp_s || dout1_c_s !== exp_s) begin
                    n_fail++;
                    $display("FAIL stream_addr%0d: got %h expected %h", i - 1, dout1_a_s, exp_s);
                end
            end
        end
        csb0  = 1'b1;
        csb1  = 1'b0;
        addr1 = 4'd15;
        tick();
        n_checks++;
        if (dout1_a_s !== 128'd45) begin
            n_fail++; $display("FAIL stream_addr15: got %h expected 2d", dout1_a_s);
        end
        go_idle();
    endtask

    // Reset during the sweep aborts it; the restart covers all 16 words.
    task automatic test_reset_mid_sweep;
        int cnt;
        csb0   = 1'b0;
        web0   = 1'b0;
        wmask0 = 16'hFFFF;
        addr0  = 4'd12;
        din0   = 128'd1;
        tick();
        go_idle();
        csb1  = 1'b0;
        addr1 = 4'd12;
        tick();
        n_checks++;
        if (dout1_a_s !== 128'd1) begin
            n_fail++; $display("FAIL prewrite_addr12: got %h expected 1", dout1_a_s);
        end
        go_idle();
        rst = 1'b1;
        tick();
        n_checks++;
        if (dout1_a_s !== {DW{1'b0}} || busy_a_s !== 1'b1) begin
            n_fail++; $display("FAIL rst_again: got dout1 %h busy %b expected 0 and 1", dout1_a_s, busy_a_s);
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        cnt = 0;
        while (busy_a_s === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        n_checks++;
        if (cnt !== 16) begin
            n_fail++; $display("FAIL restart_busy_cycles: got %0d expected 16", cnt);
        end
        csb0  = 1'b0;
        web0  = 1'b1;
        addr0 = 4'd12;
        csb1  = 1'b0;
        addr1 = 4'd12;
        tick();
        n_checks++;
        if (dout0_a_s !== {DW{1'b0}} || dout1_a_s !== {DW{1'b0}}) begin
            n_fail++; $display("FAIL restart_clears_addr12: got %h / %h expected 0", dout0_a_s, dout1_a_s);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_busy_gating();
        test_masked_write();
        test_collision();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
